// File: rtl/mac_pkg.sv
// Shared constants for the MAC frame accumulator slice.
//   DATA_W / PROD_W   : operand and product widths of the 8x8 multiplier
//   FRAME_LEN_DEF     : default number of products summed per result
//   ACC_W_DEF         : default accumulator / result width
//   clog2()           : counter width helper, usable in constant expressions
package mac_pkg;
  localparam int DATA_W        = 8;
  localparam int PROD_W        = 16;
  localparam int FRAME_LEN_DEF = 16;
  localparam int ACC_W_DEF     = 18;

  // ceil(log2(v)); 1 for v<=2 so a frame of two still gets a 1-bit counter
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction
endpackage

// File: rtl/mac_frame_accumulator_multiplier.sv
// Combinational 8x8 unsigned array multiplier (module name kept as
// "multiplier" so existing instantiations keep working).
//   a, b : unsigned 8-bit operands
//   z    : 16-bit product a*b
module multiplier (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] z
);
  // Row i of the array adds a<<i when b[i] is set.
  logic [15:0] w_row [0:8];
  assign w_row[0] = '0;

  genvar i;
  generate
    for (i = 0; i < 8; i++) begin : g_row
      assign w_row[i+1] = w_row[i] + ((16'(a) << i) & {16{b[i]}});
    end
  endgenerate

  assign z = w_row[8];
endmodule

// File: rtl/mac_frame_accumulator.sv
// Multiply-accumulate frame stage: operand pairs stream in, FRAME_LEN
// products are summed, and each frame's sum is offered on an output stream.
//   clk, rst             : clock, asynchronous active-high reset
//   clr                  : synchronous flush of pipeline, accumulator, result
//   in_valid/in_ready    : operand stream handshake, in_a/in_b operands
//   out_valid/out_ready  : result stream handshake
//   out_sum              : frame sum modulo 2^ACC_W
//   out_ovf              : a carry out of ACC_W happened within the frame
module mac_frame_accumulator
  import mac_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int ACC_W     = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);
  localparam int             CNT_W = clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  logic              r_v1, r_v2;
  logic [DATA_W-1:0] r_a, r_b;
  logic [PROD_W-1:0] r_p;
  logic [ACC_W-1:0]  r_acc;
  logic              r_ovf;
  logic [CNT_W-1:0]  r_cnt;
  logic [ACC_W-1:0]  r_out_sum;
  logic              r_out_ovf;
  logic              r_out_valid;

  logic              w_en;
  logic [PROD_W-1:0] w_z;
  logic [ACC_W:0]    w_sum;

  // Whole pipeline moves together; a held result freezes every stage.
  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en && !clr;

  // Extra top bit of w_sum is the carry out of the accumulator.
  assign w_sum = {1'b0, r_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, r_p};

  multiplier u_mul (
    .a (r_a),
    .b (r_b),
    .z (w_z)
  );

  // Stage 1: operand registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_a  <= '0;
      r_b  <= '0;
    end else if (clr) begin
      r_v1 <= 1'b0;
    end else if (w_en) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_a <= in_a;
        r_b <= in_b;
      end
    end
  end

  // Stage 2: product register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2 <= 1'b0;
      r_p  <= '0;
    end else if (clr) begin
      r_v2 <= 1'b0;
    end else if (w_en) begin
      r_v2 <= r_v1;
      r_p  <= w_z;
    end
  end

  // Accumulate stage and result register. Under w_en a presented result is
  // either retired or absent, so out_valid drops unless a frame closes now.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_cnt       <= '0;
      r_out_sum   <= '0;
      r_out_ovf   <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (clr) begin
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_en) begin
      r_out_valid <= 1'b0;
      if (r_v2) begin
        if (r_cnt == LAST) begin
          r_out_sum   <= w_sum[ACC_W-1:0];
          r_out_ovf   <= r_ovf | w_sum[ACC_W];
          r_out_valid <= 1'b1;
          r_acc       <= '0;
          r_ovf       <= 1'b0;
          r_cnt       <= '0;
        end else begin
          r_acc <= w_sum[ACC_W-1:0];
          r_ovf <= r_ovf | w_sum[ACC_W];
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_ovf   = r_out_ovf;
endmodule

// File: tb/tb_mac_frame_accumulator.sv
module tb_mac_frame_accumulator;
  localparam int FL    = 16;
  localparam int ACC_W = 18;

  logic             clk = 1'b0;
  logic             rst, clr, in_valid, out_ready;
  logic [7:0]       in_a, in_b;
  logic             in_ready, out_valid, out_ovf;
  logic [ACC_W-1:0] out_sum;

  mac_frame_accumulator #(.FRAME_LEN(FL), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: every accepted pair adds a*b to a running frame total;
  // each FRAME_LEN-th accept closes the frame into an expected result.
  typedef struct { int sum; bit ovf; } res_t;
  res_t             expq[$];
  longint           psum = 0;
  int               pcnt = 0;
  int               retired = 0;
  logic [ACC_W-1:0] last_sum = '0;
  logic             last_ovf = 1'b0;
  bit               hold = 0;
  logic [ACC_W-1:0] hsum;
  logic             hovf;

  always @(posedge clk or posedge rst) begin
    res_t r;
    if (rst || clr) begin
      psum = 0; pcnt = 0; hold = 0;
      expq.delete();
    end else begin
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      if (hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_sum", out_sum, hsum);
        chk("hold_ovf", out_ovf, hovf);
      end
      hold = out_valid && !out_ready;
      hsum = out_sum;
      hovf = out_ovf;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) chk("spurious_result", 1, 0);
        else begin
          r = expq.pop_front();
          chk("out_sum", out_sum, r.sum);
          chk("out_ovf", out_ovf, r.ovf);
        end
        last_sum = out_sum;
        last_ovf = out_ovf;
        retired++;
      end
      if (in_valid && in_ready) begin
        psum += longint'(in_a) * longint'(in_b);
        pcnt++;
        if (pcnt == FL) begin
          r.sum = int'(psum % (longint'(1) << ACC_W));
          r.ovf = (psum >= (longint'(1) << ACC_W));
          expq.push_back(r);
          psum = 0; pcnt = 0;
        end
      end
    end
  end

  // Offer one pair at the next negedge and hold it until accepted.
  task automatic send(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b;
    forever begin
      #1;
      if (in_ready) break;
      @(negedge clk);
      n++;
      if (n > 200) begin
        chk("send_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_ret(input int target);
    int n = 0;
    while (retired < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("wait_result", retired >= target, 1);
  endtask

  initial begin
    int base;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_ovf", out_ovf, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_in_ready", in_ready, 1);

    // Ones frame with latency check
    for (int i = 0; i < FL; i++) send(8'd1, 8'd1);
    @(negedge clk); chk("lat_e0", out_valid, 0);
    @(negedge clk); chk("lat_e1", out_valid, 0);
    @(negedge clk); chk("lat_e2", out_valid, 1);
    wait_ret(1);
    chk("ones_sum", last_sum, 16);
    chk("ones_ovf", last_ovf, 0);

    // Ramp frame
    for (int i = 0; i < FL; i++) send(8'(i), 8'd2);
    wait_ret(2);
    chk("ramp_sum", last_sum, 240);
    chk("ramp_ovf", last_ovf, 0);

    // Overflow frame, then flag must not leak into the next frame
    for (int i = 0; i < FL; i++) send(8'd255, 8'd255);
    wait_ret(3);
    chk("max_sum", last_sum, 253968);
    chk("max_ovf", last_ovf, 1);
    for (int i = 0; i < FL; i++) send(8'd1, 8'd1);
    wait_ret(4);
    chk("after_ovf_sum", last_sum, 16);
    chk("after_ovf_ovf", last_ovf, 0);

    // Backpressure across two back-to-back frames
    base = retired;
    fork
      begin
        for (int i = 0; i < FL; i++) send(8'd1, 8'd1);
        for (int i = 0; i < FL; i++) send(8'd2, 8'd1);
      end
      begin
        int n = 0;
        while (!out_valid && n < 400) begin
          @(negedge clk);
          n++;
        end
        chk("bp_seen_result", out_valid, 1);
        out_ready = 1'b0;
        repeat (5) begin
          @(posedge clk);
          @(negedge clk);
          #1;
          chk("bp_in_ready", in_ready, 0);
          chk("bp_valid", out_valid, 1);
          chk("bp_sum", out_sum, 16);
        end
        out_ready = 1'b1;
      end
    join
    wait_ret(base + 2);
    chk("bp_second_sum", last_sum, 32);

    // Random operands with ~50% bubbles
    base = retired;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < FL; i++) begin
        while ($urandom_range(1) == 1) @(negedge clk);
        send(8'($urandom), 8'($urandom));
      end
    wait_ret(base + 3);

    // Flush mid-frame; the pair offered with clr must be dropped
    for (int i = 0; i < 7; i++) send(8'($urandom), 8'($urandom));
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9;
    #1 chk("clr_in_ready", in_ready, 0);
    @(posedge clk);
    #1 begin clr = 1'b0; in_valid = 1'b0; end
    chk("clr_out_valid", out_valid, 0);
    base = retired;
    for (int i = 0; i < FL; i++) send(8'd3, 8'd3);
    wait_ret(base + 1);
    chk("clr_sum", last_sum, 144);
    chk("clr_ovf", last_ovf, 0);

    // Asynchronous reset mid-frame
    for (int i = 0; i < 9; i++) send(8'd5, 8'd5);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_sum", out_sum, 0);
    chk("midrst_ovf", out_ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("midrst_in_ready", in_ready, 1);
    base = retired;
    for (int i = 0; i < FL; i++) send(8'd1, 8'd1);
    wait_ret(base + 1);
    chk("post_rst_sum", last_sum, 16);
    chk("post_rst_ovf", last_ovf, 0);

    repeat (4) @(negedge clk);
    chk("no_pending_results", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
